led_breathe: RTL and testbench



---
 rtl/led_breathe.sv | 120 ++++++++++++
 tb/tb_led_breathe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe.sv
// Breathing-LED PWM driver stepped by a slow external clock (e.g. clk_div output).
// Slow-clock edges become ticks; each tick moves a duty ramp FSM, and duty only changes at PWM period wrap.
module led_breathe #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int HOLD  = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ce,
    input  logic             slow_in,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty,
    output logic [1:0]       state,
    output logic             cycle_done
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [WIDTH-1:0] DUTY_MAX  = '1;
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_HOLD_HI = 2'd1,
        ST_DOWN    = 2'd2,
        ST_HOLD_LO = 2'd3
    } state_t;

    logic [2:0]       sync_reg;
    logic [2:0]       sync_next;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] duty_reg;
    logic [HW-1:0]    hold_cnt_reg;
    logic             pending_reg;
    logic             pwm_reg;
    logic             cycle_done_reg;
    state_t           state_reg;

    logic             tick;
    logic             boundary;
    logic             step;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] down_next;

    assign sync_next = {sync_reg[1:0], slow_in};
    assign tick      = sync_reg[1] & ~sync_reg[2];
    assign boundary  = ce && (cnt_reg == DUTY_MAX);
    assign step      = boundary && (pending_reg || tick);

    // Saturating ramp math done by comparing against headroom, so nothing ever wraps.
    assign up_next   = ((DUTY_MAX - duty_reg) > STEP_W) ? (duty_reg + STEP_W) : DUTY_MAX;
    assign down_next = (duty_reg > STEP_W) ? (duty_reg - STEP_W) : '0;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_reg       <= '0;
            cnt_reg        <= '0;
            duty_reg       <= '0;
            hold_cnt_reg   <= '0;
            pending_reg    <= 1'b0;
            pwm_reg        <= 1'b0;
            cycle_done_reg <= 1'b0;
            state_reg      <= ST_UP;
        end else begin
            cycle_done_reg <= 1'b0;
            if (ce) begin
                sync_reg <= sync_next;
                cnt_reg  <= cnt_reg + 1'b1;
                pwm_reg  <= (cnt_reg < duty_reg);
                if (boundary) begin
                    pending_reg <= 1'b0;
                end else if (tick) begin
                    pending_reg <= 1'b1;
                end
                if (step) begin
                    case (state_reg)
                        ST_UP: begin
                            duty_reg <= up_next;
                            if (up_next == DUTY_MAX) begin
                                state_reg    <= ST_HOLD_HI;
                                hold_cnt_reg <= '0;
                            end
                        end
                        ST_HOLD_HI: begin
                            if (hold_cnt_reg == HOLD_LAST) begin
                                state_reg    <= ST_DOWN;
                                hold_cnt_reg <= '0;
                            end else begin
                                hold_cnt_reg <= hold_cnt_reg + 1'b1;
                            end
                        end
                        ST_DOWN: begin
                            duty_reg <= down_next;
                            if (down_next == '0) begin
                                state_reg    <= ST_HOLD_LO;
                                hold_cnt_reg <= '0;
                            end
                        end
                        ST_HOLD_LO: begin
                            if (hold_cnt_reg == HOLD_LAST) begin
                                state_reg      <= ST_UP;
                                hold_cnt_reg   <= '0;
                                cycle_done_reg <= 1'b1;
                            end else begin
                                hold_cnt_reg <= hold_cnt_reg + 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign pwm_out    = pwm_reg;
    assign duty       = duty_reg;
    assign state      = state_reg;
    assign cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: two instances (STEP=1 and STEP=4) driven by the same stimulus,
// compared every clock against a model that walks a precomputed breath sequence.
module tb_led_breathe;

    localparam int WIDTH = 4;
    localparam int HOLD  = 2;
    localparam int MAXV  = 15;

    logic       clk_in;
    logic       rst;
    logic       ce;
    logic       slow_in;
    logic       pwm_a, pwm_b;
    logic [3:0] duty_a, duty_b;
    logic [1:0] state_a, state_b;
    logic       cd_a, cd_b;

    led_breathe #(.WIDTH(WIDTH), .STEP(1), .HOLD(HOLD)) dut_a (
        .clk_in(clk_in), .rst(rst), .ce(ce), .slow_in(slow_in),
        .pwm_out(pwm_a), .duty(duty_a), .state(state_a), .cycle_done(cd_a)
    );

    led_breathe #(.WIDTH(WIDTH), .STEP(4), .HOLD(HOLD)) dut_b (
        .clk_in(clk_in), .rst(rst), .ce(ce), .slow_in(slow_in),
        .pwm_out(pwm_b), .duty(duty_b), .state(state_b), .cycle_done(cd_b)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: breath sequence per instance, indexed by number of applied steps mod length.
    int seq_d[2][64];
    int seq_s[2][64];
    int seq_len[2];
    int step_of[2] = '{1, 4};

    int cnt_m;
    bit pend_m;
    bit h0, h1, h2;
    int pos_m[2];
    bit pwm_m[2];
    bit cd_m[2];
    int cd_seen_a;
    int rise_no;

    task automatic build_seq();
        for (int i = 0; i < 2; i++) begin
            int st, nu, p, v;
            st = step_of[i];
            nu = (MAXV + st - 1) / st;
            p = 0;
            seq_d[i][0] = 0;
            seq_s[i][0] = 0;
            for (int k = 1; k <= nu; k++) begin
                p++;
                v = k * st;
                seq_d[i][p] = (v > MAXV) ? MAXV : v;
                seq_s[i][p] = (k == nu) ? 1 : 0;
            end
            for (int k = 1; k <= HOLD; k++) begin
                p++;
                seq_d[i][p] = MAXV;
                seq_s[i][p] = (k == HOLD) ? 2 : 1;
            end
            for (int k = 1; k <= nu; k++) begin
                p++;
                v = MAXV - k * st;
                seq_d[i][p] = (v < 0) ? 0 : v;
                seq_s[i][p] = (k == nu) ? 3 : 2;
            end
            for (int k = 1; k < HOLD; k++) begin
                p++;
                seq_d[i][p] = 0;
                seq_s[i][p] = 3;
            end
            seq_len[i] = p + 1;
        end
    endtask

    task automatic model_edge();
        bit tick, bnd, applied;
        if (rst) begin
            cnt_m = 0; pend_m = 0; h0 = 0; h1 = 0; h2 = 0;
            for (int i = 0; i < 2; i++) begin
                pos_m[i] = 0; pwm_m[i] = 0; cd_m[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) cd_m[i] = 0;
            if (ce) begin
                tick    = h1 && !h2;
                bnd     = (cnt_m == MAXV);
                applied = bnd && (pend_m || tick);
                for (int i = 0; i < 2; i++) begin
                    pwm_m[i] = (cnt_m < seq_d[i][pos_m[i]]);
                    if (applied) begin
                        pos_m[i] = (pos_m[i] + 1) % seq_len[i];
                        cd_m[i]  = (pos_m[i] == 0);
                    end
                end
                pend_m = bnd ? 1'b0 : (pend_m || tick);
                cnt_m  = (cnt_m + 1) % (MAXV + 1);
                h2 = h1; h1 = h0; h0 = slow_in;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("duty_a",  32'(duty_a),  seq_d[0][pos_m[0]]);
        check_eq("state_a", 32'(state_a), seq_s[0][pos_m[0]]);
        check_eq("pwm_a",   32'(pwm_a),   32'(pwm_m[0]));
        check_eq("cd_a",    32'(cd_a),    32'(cd_m[0]));
        check_eq("duty_b",  32'(duty_b),  seq_d[1][pos_m[1]]);
        check_eq("state_b", 32'(state_b), seq_s[1][pos_m[1]]);
        check_eq("pwm_b",   32'(pwm_b),   32'(pwm_m[1]));
        check_eq("cd_b",    32'(cd_b),    32'(cd_m[1]));
        if (cd_a) cd_seen_a++;
    endtask

    task automatic cycle(input logic ce_v, input logic slow_v, input logic rst_v);
        @(negedge clk_in);
        ce = ce_v; slow_in = slow_v; rst = rst_v;
        @(posedge clk_in);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_cnt(input int target);
        int guard = 0;
        while (cnt_m != target && guard < 40) begin
            cycle(1'b1, 1'b0, 1'b0);
            guard++;
        end
    endtask

    task automatic do_rise(input int hi, input int lo, input bit rand_ce);
        logic ce_v;
        for (int i = 0; i < hi + lo; i++) begin
            ce_v = rand_ce ? ($urandom_range(0, 7) != 0) : 1'b1;
            cycle(ce_v, (i < hi) ? 1'b1 : 1'b0, 1'b0);
        end
        rise_no++;
        $display("rise %0d: duty_a=%0d state_a=%0d duty_b=%0d state_b=%0d",
                 rise_no, duty_a, state_a, duty_b, state_b);
    endtask

    int exp_b[11] = '{0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0};

    initial begin
        int ones;
        rst = 1'b1; ce = 1'b1; slow_in = 1'b0;
        cnt_m = 0; pend_m = 0; h0 = 0; h1 = 0; h2 = 0;
        cd_seen_a = 0; rise_no = 0;
        for (int i = 0; i < 2; i++) begin
            pos_m[i] = 0; pwm_m[i] = 0; cd_m[i] = 0;
        end
        build_seq();

        // Reset with slow_in toggling
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i % 2), 1'b1);
        check_eq("rst_pwm", 32'(pwm_a), 0);
        check_eq("rst_duty", 32'(duty_a), 0);
        check_eq("rst_state", 32'(state_a), 0);
        check_eq("rst_cd", 32'(cd_a), 0);

        // Idle: PWM stays low
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            ones += int'(pwm_a);
        end
        check_eq("idle_pwm_ones", ones, 0);
        $display("idle 100 cycles: pwm_a high count=%0d", ones);

        // Single rise at cnt=5
        wait_cnt(5);
        do_rise(20, 20, 1'b0);
        check_eq("single_duty", 32'(duty_a), 1);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            ones += int'(pwm_a);
        end
        check_eq("single_pwm_ones", ones, 1);

        // Two rises inside one period merge into one step
        wait_cnt(0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        do_rise(20, 20, 1'b0);
        check_eq("merge_duty", 32'(duty_a), 2);

        // Tick lands exactly in the boundary cycle
        wait_cnt(13);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        check_eq("bnd_duty_now", 32'(duty_a), 3);
        do_rise(17, 20, 1'b0);
        check_eq("bnd_no_pending", 32'(duty_a), 3);
        check_eq("bnd_duty_b", 32'(duty_b), 12);

        // Full breath from reset
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cd_seen_a = 0;
        for (int r = 1; r <= 34; r++) begin
            do_rise(20, 20, 1'b0);
            if (r <= 10) check_eq("step4_duty", 32'(duty_b), exp_b[r]);
            if (r == 4)  check_eq("step4_hold_hi", 32'(state_b), 1);
            if (r == 6)  check_eq("step4_down", 32'(state_b), 2);
            if (r == 10) check_eq("step4_hold_lo", 32'(state_b), 3);
            if (r == 15) begin
                check_eq("breath_top_duty", 32'(duty_a), 15);
                check_eq("breath_top_state", 32'(state_a), 1);
            end
            if (r == 17) check_eq("breath_down_state", 32'(state_a), 2);
            if (r == 32) begin
                check_eq("breath_low_duty", 32'(duty_a), 0);
                check_eq("breath_low_state", 32'(state_a), 3);
            end
            if (r == 34) check_eq("breath_wrap_state", 32'(state_a), 0);
        end
        check_eq("breath_cd_pulses", cd_seen_a, 1);

        // ce=0 freezes everything, then reset during ce=0
        for (int r = 0; r < 3; r++) do_rise(20, 20, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'(i % 2), 1'b0);
        check_eq("ce0_duty_a", 32'(duty_a), 3);
        check_eq("ce0_duty_b", 32'(duty_b), 4);
        check_eq("ce0_cd", 32'(cd_a), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("ce0rst_duty_a", 32'(duty_a), 0);
        check_eq("ce0rst_state_a", 32'(state_a), 0);
        check_eq("ce0rst_pwm_a", 32'(pwm_a), 0);
        check_eq("ce0rst_duty_b", 32'(duty_b), 0);
        check_eq("ce0rst_state_b", 32'(state_b), 0);
        $display("ce=0 hold + reset: duty_a=%0d duty_b=%0d", duty_a, duty_b);

        // Randomised rises with intermittent ce
        for (int r = 0; r < 30; r++)
            do_rise($urandom_range(4, 30), $urandom_range(20, 60), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
